multi_channel_countdown_timer: RTL and testbench
================================================

MULTI_CHANNEL_COUNTDOWN_TIMER -- requirements
Module: multi_channel_countdown_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent countdown channels (1..16).
REQ-002 SHALL have parameter TICK_DIV, default 100_000_000: clk cycles per one-second tick (>=2).
REQ-003 SHALL have parameter RING_CYCLES, default 50_000_000: clk cycles ring stays high per expiry (>=1).
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port ch_sel, input, CW=max(1,$clog2(NUM_CH)): target channel for set_timer/reset_timer.
REQ-007 SHALL have port set_timer, input, 1: one-cycle strobe; loads the BCD inputs into ch_sel as preset and starts it.
REQ-008 SHALL have port reset_timer, input, 1: one-cycle strobe; reloads the ch_sel preset and restarts it.
REQ-009 SHALL have port pause, input, NUM_CH: level, per channel; freezes the count while high.
REQ-010 SHALL have ports hour_bcd_in, minute_bcd_in, second_bcd_in, input, 8 each: two-digit BCD preset.
REQ-011 SHALL have port rd_sel, input, CW: channel shown on the outputs.
REQ-012 SHALL have ports hour_out_bcd, minute_out_bcd, second_out_bcd, output, 8 each: remaining time of rd_sel (combinational mux of registered state).
REQ-013 SHALL have port ring, output, NUM_CH: per-channel expiry alarm.
REQ-014 SHALL have port busy, output, NUM_CH: high while the channel is in RUN or PAUSED.
REQ-015 SHALL have port set_err, output, 1: one-cycle pulse when set_timer is rejected.

Function
REQ-016 SHALL use one shared, free-running prescaler 0..TICK_DIV-1 that asserts tick for one cycle at TICK_DIV-1 and wraps to 0.
REQ-017 SHALL run a per-channel FSM with states IDLE, RUN, PAUSED, RING.
REQ-018 SHALL, on accepted set_timer, register the preset and count on that edge, then enter RUN if nonzero, else IDLE.
REQ-019 SHALL reject set_timer when any digit >9, minute >0x59, second >0x59, or ch_sel >=NUM_CH, leaving all state unchanged and pulsing set_err on the next cycle.
REQ-020 SHALL, on reset_timer, copy the preset to the count and enter RUN (IDLE if preset is zero), from any state, clearing ring.
REQ-021 SHALL move RUN->PAUSED when pause[ch]=1 and PAUSED->RUN when pause[ch]=0; ticks in PAUSED are lost, not deferred.
REQ-022 SHALL, on tick in RUN, decrement the count by one second with BCD borrow (sec 00->59 with min-1; min 00->59 with hour-1); hours range 00..99.
REQ-023 SHALL, on a tick in RUN that takes the count from 00:00:01 to 00:00:00, enter RING and raise ring[ch] on the same edge.
REQ-024 SHALL hold ring[ch] for exactly RING_CYCLES cycles, then go to IDLE with count 00:00:00.
REQ-025 SHALL apply priority set_timer > reset_timer > pause > tick when they coincide on one channel; strobes affect only ch_sel.
REQ-026 SHALL ignore pause in IDLE and RING.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear prescaler, all presets and counts to 00:00:00, all FSMs to IDLE, ring, busy and set_err to 0.
REQ-028 SHALL abort any in-progress count or ring when rst_n asserts mid-operation.

Configuration
REQ-029 SHALL, with TIMER_AUTO_RELOAD_EN defined, leave RING by reloading the preset and entering RUN (busy high again), still honouring the RING_CYCLES pulse.
REQ-030 SHALL, without TIMER_AUTO_RELOAD_EN, leave RING to IDLE per REQ-024.

Structure
REQ-031 SHALL place the FSM state enum, the BCD hh:mm:ss struct and the BCD limit constants in package timer_pkg.
REQ-032 SHALL implement one channel (FSM, preset, count, ring counter) in sub-module countdown_channel, instantiated NUM_CH times.

Verification (NUM_CH=2, TICK_DIV=4, RING_CYCLES=3)
REQ-033 SHALL check: set ch0 01:30:15 -> outputs 01:30:15 the next cycle; after 5 ticks -> 01:30:10, busy[0]=1.
REQ-034 SHALL check: set ch1 00:01:00, one tick -> 00:00:59; set 01:00:00, one tick -> 00:59:59.
REQ-035 SHALL check: set ch0 00:00:02, pause[0]=1 across 3 ticks -> count stays 00:00:02; release -> reaches 00:00:00 after 2 ticks, ring[0]=1 for exactly 3 cycles, then IDLE.
REQ-036 SHALL check: set with second_bcd_in=0x60 or 0x1A -> set_err pulses, channel state unchanged.
REQ-037 SHALL check: set_timer and reset_timer in the same cycle -> new preset loaded; reset_timer mid-RING -> ring drops, count = preset.
REQ-038 SHALL check: with TIMER_AUTO_RELOAD_EN, preset 00:00:02 -> ring pulses every 2 ticks plus RING_CYCLES; rst_n low mid-count -> all outputs zero at once.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared types and BCD helpers for the multi-channel countdown timer.
//   ch_state_e : per-channel FSM state (IDLE, RUN, PAUSED, RING)
//   hms_t      : packed two-digit-BCD hh:mm:ss value (hh in [23:16], ss in [7:0])
//   BCD_*      : digit and field limits used for validation and borrow wrap
//   hms_valid  : true when every digit is 0..9 and minutes/seconds are <= 59
//   hms_dec    : subtract one second with BCD borrow through minutes and hours
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_RING   = 2'd3
    } ch_state_e;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } hms_t;

    localparam logic [3:0] BCD_DIGIT_MAX    = 4'h9;
    localparam logic [3:0] BCD_MS_TENS_MAX  = 4'h5;
    localparam logic [7:0] BCD_MS_WRAP      = 8'h59;
    localparam logic [7:0] BCD_HH_WRAP      = 8'h99;
    localparam hms_t       HMS_ZERO         = hms_t'(24'h00_00_00);
    localparam hms_t       HMS_ONE          = hms_t'(24'h00_00_01);

    // Two-digit BCD minus one; a field at 00 takes the wrap value.
    function automatic logic [7:0] bcd2_dec(input logic [7:0] v, input logic [7:0] wrap);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = wrap;
        end else if (v[3:0] == 4'h0) begin
            r = {v[7:4] - 4'h1, BCD_DIGIT_MAX};
        end else begin
            r = {v[7:4], v[3:0] - 4'h1};
        end
        return r;
    endfunction

    function automatic hms_t hms_dec(input hms_t t);
        hms_t r;
        r    = t;
        r.ss = bcd2_dec(t.ss, BCD_MS_WRAP);
        if (t.ss == 8'h00) begin
            r.mm = bcd2_dec(t.mm, BCD_MS_WRAP);
            if (t.mm == 8'h00) begin
                r.hh = bcd2_dec(t.hh, BCD_HH_WRAP);
            end
        end
        return r;
    endfunction

    function automatic logic hms_valid(input hms_t t);
        return (t.hh[7:4] <= BCD_DIGIT_MAX)   && (t.hh[3:0] <= BCD_DIGIT_MAX) &&
               (t.mm[7:4] <= BCD_MS_TENS_MAX) && (t.mm[3:0] <= BCD_DIGIT_MAX) &&
               (t.ss[7:4] <= BCD_MS_TENS_MAX) && (t.ss[3:0] <= BCD_DIGIT_MAX);
    endfunction

endpackage

// File: rtl/countdown_channel.sv
// countdown_channel: one countdown channel (FSM, preset, count, ring counter).
// Build option: TIMER_AUTO_RELOAD_EN -- when defined, leaving RING reloads the
// preset and restarts the count instead of going to IDLE.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_set       : accepted set strobe for this channel (preset already validated)
//   i_reload    : reset_timer strobe for this channel
//   i_pause     : pause level for this channel
//   i_tick      : shared one-second tick
//   i_preset    : BCD hh:mm:ss to load on i_set
//   o_count     : registered remaining time
//   o_ring      : registered expiry alarm
//   o_busy      : registered, high in RUN or PAUSED
//   o_state     : current FSM state (debug)
module countdown_channel
    import timer_pkg::*;
#(
    parameter int RING_CYCLES = 50_000_000
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_set,
    input  logic        i_reload,
    input  logic        i_pause,
    input  logic        i_tick,
    input  logic [23:0] i_preset,
    output logic [23:0] o_count,
    output logic        o_ring,
    output logic        o_busy,
    output logic [1:0]  o_state
);

    localparam int RW = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;

    ch_state_e       r_state;
    hms_t            r_preset;
    hms_t            r_count;
    logic [RW-1:0]   r_ring_cnt;
    logic            r_ring;
    logic            r_busy;

    logic            w_load;
    hms_t            w_load_val;

    // set and reset_timer share the load path; set brings its own value.
    assign w_load     = i_set | i_reload;
    assign w_load_val = i_set ? hms_t'(i_preset) : r_preset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_preset   <= HMS_ZERO;
            r_count    <= HMS_ZERO;
            r_ring_cnt <= '0;
            r_ring     <= 1'b0;
            r_busy     <= 1'b0;
        end else if (w_load) begin
            // Strobes beat pause and tick, and abort any ring in progress.
            if (i_set) begin
                r_preset <= w_load_val;
            end
            r_count    <= w_load_val;
            r_ring     <= 1'b0;
            r_ring_cnt <= '0;
            if (w_load_val != HMS_ZERO) begin
                r_state <= ST_RUN;
                r_busy  <= 1'b1;
            end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_pause) begin
                        r_state <= ST_PAUSED;
                    end else if (i_tick) begin
                        if (r_count == HMS_ONE) begin
                            r_count    <= HMS_ZERO;
                            r_state    <= ST_RING;
                            r_ring     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_ring_cnt <= '0;
                        end else begin
                            r_count <= hms_dec(r_count);
                        end
                    end
                end
                ST_PAUSED: begin
                    // Ticks seen here are dropped, not queued.
                    if (!i_pause) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RING: begin
                    if (r_ring_cnt == RW'(RING_CYCLES - 1)) begin
                        r_ring     <= 1'b0;
                        r_ring_cnt <= '0;
`ifdef TIMER_AUTO_RELOAD_EN
                        r_count <= r_preset;
                        if (r_preset != HMS_ZERO) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
`else
                        r_count <= HMS_ZERO;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
`endif
                    end else begin
                        r_ring_cnt <= r_ring_cnt + RW'(1);
                    end
                end
                default: begin
                    // IDLE waits for a strobe; pause has no effect.
                end
            endcase
        end
    end

    assign o_count = r_count;
    assign o_ring  = r_ring;
    assign o_busy  = r_busy;
    assign o_state = r_state;

endmodule

// File: rtl/multi_channel_countdown_timer.sv
// multi_channel_countdown_timer: NUM_CH independent hh:mm:ss BCD countdown
// channels sharing one free-running one-second prescaler.
// Build option: TIMER_AUTO_RELOAD_EN -- channels restart from their preset
// after each ring pulse instead of returning to IDLE.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   ch_sel                      : channel targeted by set_timer / reset_timer
//   set_timer                   : strobe, load BCD inputs as preset and start
//   reset_timer                 : strobe, reload preset and restart
//   pause[NUM_CH]               : per-channel freeze level
//   hour/minute/second_bcd_in   : BCD preset value
//   rd_sel                      : channel shown on the *_out_bcd outputs
//   hour/minute/second_out_bcd  : remaining time of rd_sel
//   ring[NUM_CH], busy[NUM_CH]  : per-channel alarm and activity
//   set_err                     : one-cycle pulse after a rejected set_timer
//   o_state_dbg                 : 2 bits of FSM state per channel (debug)
module multi_channel_countdown_timer
    import timer_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int TICK_DIV    = 100_000_000,
    parameter int RING_CYCLES = 50_000_000,
    localparam int CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CW-1:0]       ch_sel,
    input  logic                set_timer,
    input  logic                reset_timer,
    input  logic [NUM_CH-1:0]   pause,
    input  logic [7:0]          hour_bcd_in,
    input  logic [7:0]          minute_bcd_in,
    input  logic [7:0]          second_bcd_in,
    input  logic [CW-1:0]       rd_sel,
    output logic [7:0]          hour_out_bcd,
    output logic [7:0]          minute_out_bcd,
    output logic [7:0]          second_out_bcd,
    output logic [NUM_CH-1:0]   ring,
    output logic [NUM_CH-1:0]   busy,
    output logic                set_err,
    output logic [2*NUM_CH-1:0] o_state_dbg
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] r_presc;
    logic          r_set_err;
    logic          w_tick;
    hms_t          w_preset_in;
    logic          w_ch_ok;
    logic          w_set_ok;
    logic [23:0]   w_count [NUM_CH];
    logic [23:0]   w_rd;

    assign w_tick      = (r_presc == PW'(TICK_DIV - 1));
    assign w_preset_in = {hour_bcd_in, minute_bcd_in, second_bcd_in};
    assign w_ch_ok     = (int'(ch_sel) < NUM_CH);
    assign w_set_ok    = set_timer && w_ch_ok && hms_valid(w_preset_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_set_err <= 1'b0;
        end else begin
            r_presc   <= w_tick ? '0 : r_presc + PW'(1);
            r_set_err <= set_timer && !w_set_ok;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_hit;
        assign w_hit = (ch_sel == CW'(g));

        countdown_channel #(
            .RING_CYCLES (RING_CYCLES)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_set    (w_set_ok && w_hit),
            .i_reload (reset_timer && w_hit),
            .i_pause  (pause[g]),
            .i_tick   (w_tick),
            .i_preset (w_preset_in),
            .o_count  (w_count[g]),
            .o_ring   (ring[g]),
            .o_busy   (busy[g]),
            .o_state  (o_state_dbg[2*g +: 2])
        );
    end

    // Out-of-range rd_sel reads as 00:00:00.
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == CW'(i)) begin
                w_rd = w_count[i];
            end
        end
    end

    assign hour_out_bcd   = w_rd[23:16];
    assign minute_out_bcd = w_rd[15:8];
    assign second_out_bcd = w_rd[7:0];
    assign set_err        = r_set_err;

endmodule

// File: tb/tb_multi_channel_countdown_timer.sv
module tb_multi_channel_countdown_timer;

    localparam int NUM_CH      = 2;
    localparam int TICK_DIV    = 4;
    localparam int RING_CYCLES = 3;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_RING   = 2'd3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                ch_sel;
    logic                set_timer;
    logic                reset_timer;
    logic [NUM_CH-1:0]   pause;
    logic [7:0]          hour_bcd_in;
    logic [7:0]          minute_bcd_in;
    logic [7:0]          second_bcd_in;
    logic                rd_sel;
    logic [7:0]          hour_out_bcd;
    logic [7:0]          minute_out_bcd;
    logic [7:0]          second_out_bcd;
    logic [NUM_CH-1:0]   ring;
    logic [NUM_CH-1:0]   busy;
    logic                set_err;
    logic [2*NUM_CH-1:0] o_state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    multi_channel_countdown_timer #(
        .NUM_CH      (NUM_CH),
        .TICK_DIV    (TICK_DIV),
        .RING_CYCLES (RING_CYCLES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ch_sel         (ch_sel),
        .set_timer      (set_timer),
        .reset_timer    (reset_timer),
        .pause          (pause),
        .hour_bcd_in    (hour_bcd_in),
        .minute_bcd_in  (minute_bcd_in),
        .second_bcd_in  (second_bcd_in),
        .rd_sel         (rd_sel),
        .hour_out_bcd   (hour_out_bcd),
        .minute_out_bcd (minute_out_bcd),
        .second_out_bcd (second_out_bcd),
        .ring           (ring),
        .busy           (busy),
        .set_err        (set_err),
        .o_state_dbg    (o_state_dbg)
    );

    // Reference one-second tick: the next rising edge is a tick edge
    // whenever the reference prescaler sits at TICK_DIV-1.
    logic [1:0] ref_presc;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ref_presc <= 2'd0;
        else        ref_presc <= ref_presc + 2'd1;
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] shown();
        return {hour_out_bcd, minute_out_bcd, second_out_bcd};
    endfunction

    function automatic logic [1:0] st(input int ch);
        return o_state_dbg[2*ch +: 2];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input logic ch);
        rd_sel = ch;
        #1;
    endtask

    // Returns at the falling edge right after the n-th tick edge.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            while (ref_presc != 2'd3 && guard < 2 * TICK_DIV) begin
                @(negedge clk);
                guard++;
            end
            if (ref_presc != 2'd3) check("tick_timeout", 32'(guard), 32'(2 * TICK_DIV + 1));
            @(negedge clk);
        end
    endtask

    task automatic do_set(input logic ch, input logic [7:0] hh, input logic [7:0] mm,
                          input logic [7:0] ss, input logic with_reset);
        ch_sel        = ch;
        hour_bcd_in   = hh;
        minute_bcd_in = mm;
        second_bcd_in = ss;
        set_timer     = 1'b1;
        reset_timer   = with_reset;
        @(negedge clk);
        set_timer     = 1'b0;
        reset_timer   = 1'b0;
    endtask

    task automatic do_reload(input logic ch);
        ch_sel      = ch;
        reset_timer = 1'b1;
        @(negedge clk);
        reset_timer = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed vectors ----------------
    initial begin
        rst_n         = 1'b0;
        ch_sel        = 1'b0;
        set_timer     = 1'b0;
        reset_timer   = 1'b0;
        pause         = '0;
        hour_bcd_in   = '0;
        minute_bcd_in = '0;
        second_bcd_in = '0;
        rd_sel        = 1'b0;

        cyc(2);
        check("rst_count", 32'(shown()), 32'h0);
        check("rst_ring",  32'(ring),    32'h0);
        check("rst_busy",  32'(busy),    32'h0);
        check("rst_err",   32'(set_err), 32'h0);
        check("rst_state", 32'(o_state_dbg), 32'h0);
        rst_n = 1'b1;

        // Load and count down with no borrow.
        show(1'b0);
        do_set(1'b0, 8'h01, 8'h30, 8'h15, 1'b0);
        check("t1_load", 32'(shown()), 32'h013015);
        check("t1_busy", 32'(busy),    32'h1);
        wait_ticks(5);
        check("t1_5tick", 32'(shown()), 32'h013010);
        check("t1_busy0", 32'(busy[0]), 32'h1);

        // Borrow from minutes, then from hours.
        show(1'b1);
        do_set(1'b1, 8'h00, 8'h01, 8'h00, 1'b0);
        check("t2_load_a", 32'(shown()), 32'h000100);
        wait_ticks(1);
        check("t2_borrow_min", 32'(shown()), 32'h000059);
        do_set(1'b1, 8'h01, 8'h00, 8'h00, 1'b0);
        check("t2_load_b", 32'(shown()), 32'h010000);
        wait_ticks(1);
        check("t2_borrow_hr", 32'(shown()), 32'h005959);
        show(1'b0);
        check("t2_ch0_indep", 32'(shown()), 32'h013008);
        check("t2_busy", 32'(busy), 32'h3);

        // Pause holds the count; release lets it expire and ring.
        pause[0] = 1'b1;
        do_set(1'b0, 8'h00, 8'h00, 8'h02, 1'b0);
        check("t3_load", 32'(shown()), 32'h000002);
        wait_ticks(3);
        check("t3_paused_cnt", 32'(shown()), 32'h000002);
        check("t3_paused_st",  32'(st(0)),   32'(S_PAUSED));
        check("t3_paused_busy", 32'(busy[0]), 32'h1);
        pause[0] = 1'b0;
        wait_ticks(1);
        check("t3_one", 32'(shown()), 32'h000001);
        wait_ticks(1);
        check("t3_zero",   32'(shown()), 32'h000000);
        check("t3_ring_c1", 32'(ring[0]), 32'h1);
        check("t3_ring_st", 32'(st(0)),   32'(S_RING));
        check("t3_ring_busy", 32'(busy[0]), 32'h0);
        pause[0] = 1'b1;
        cyc(1);
        check("t3_ring_c2", 32'(ring[0]), 32'h1);
        cyc(1);
        check("t3_ring_c3", 32'(ring[0]), 32'h1);
        cyc(1);
        check("t3_ring_off", 32'(ring[0]), 32'h0);
        pause[0] = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
        check("t3_reload_st",   32'(st(0)),   32'(S_RUN));
        check("t3_reload_busy", 32'(busy[0]), 32'h1);
        check("t3_reload_cnt",  32'(shown()), 32'h000002);
        wait_ticks(2);
        check("t3_rering_c1", 32'(ring[0]), 32'h1);
        check("t3_rering_cnt", 32'(shown()), 32'h000000);
        cyc(1);
        check("t3_rering_c2", 32'(ring[0]), 32'h1);
        cyc(1);
        check("t3_rering_c3", 32'(ring[0]), 32'h1);
        cyc(1);
        check("t3_rering_off", 32'(ring[0]), 32'h0);
        check("t3_rering_cnt2", 32'(shown()), 32'h000002);
`else
        check("t3_idle_st",   32'(st(0)),   32'(S_IDLE));
        check("t3_idle_busy", 32'(busy[0]), 32'h0);
        check("t3_idle_cnt",  32'(shown()), 32'h000000);
        pause[0] = 1'b1;
        wait_ticks(2);
        check("t3_stay_idle", 32'(st(0)),   32'(S_IDLE));
        check("t3_no_rering", 32'(ring[0]), 32'h0);
        pause[0] = 1'b0;
`endif

        // Rejected presets leave the channel alone and pulse set_err.
        show(1'b1);
        pause[1] = 1'b1;
        do_set(1'b1, 8'h00, 8'h10, 8'h00, 1'b0);
        check("t4_load",   32'(shown()), 32'h001000);
        check("t4_no_err", 32'(set_err), 32'h0);
        cyc(1);
        check("t4_paused", 32'(st(1)), 32'(S_PAUSED));
        do_set(1'b1, 8'h00, 8'h00, 8'h60, 1'b0);
        check("t4_err_60",   32'(set_err), 32'h1);
        check("t4_keep_60",  32'(shown()), 32'h001000);
        cyc(1);
        check("t4_err_drop", 32'(set_err), 32'h0);
        do_set(1'b1, 8'h00, 8'h00, 8'h1A, 1'b0);
        check("t4_err_1a",  32'(set_err), 32'h1);
        check("t4_keep_1a", 32'(shown()), 32'h001000);
        check("t4_st_1a",   32'(st(1)),   32'(S_PAUSED));
        check("t4_busy_1a", 32'(busy[1]), 32'h1);
        cyc(1);
        do_set(1'b1, 8'hA0, 8'h00, 8'h00, 1'b0);
        check("t4_err_hr", 32'(set_err), 32'h1);
        check("t4_keep_hr", 32'(shown()), 32'h001000);
        cyc(1);

        // set beats reset_timer; reset_timer mid-ring restarts from preset.
        pause[1] = 1'b0;
        do_set(1'b1, 8'h00, 8'h00, 8'h03, 1'b1);
        check("t5_set_wins", 32'(shown()), 32'h000003);
        check("t5_run",      32'(st(1)),   32'(S_RUN));
        wait_ticks(3);
        check("t5_ring",     32'(ring[1]), 32'h1);
        check("t5_ring_cnt", 32'(shown()), 32'h000000);
        do_reload(1'b1);
        check("t5_ring_drop", 32'(ring[1]), 32'h0);
        check("t5_reloaded",  32'(shown()), 32'h000003);
        check("t5_busy",      32'(busy[1]), 32'h1);

        // Asynchronous reset in the middle of a count.
        rst_n = 1'b0;
        #1;
        check("t6_cnt1",  32'(shown()), 32'h0);
        check("t6_ring",  32'(ring),    32'h0);
        check("t6_busy",  32'(busy),    32'h0);
        check("t6_err",   32'(set_err), 32'h0);
        check("t6_state", 32'(o_state_dbg), 32'h0);
        show(1'b0);
        check("t6_cnt0",  32'(shown()), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("t6_post_busy", 32'(busy), 32'h0);
        show(1'b1);
        check("t6_post_cnt1", 32'(shown()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
